// File: rtl/barrel_shifter_pipe.sv
// Pipelined shift/rotate unit: ROL/ROR/SLL/SRA with a valid/ready stream and a sideband tag.
// The accept edge captures the operand into stage 0; each later register applies one power-of-two shift.

module bsp_shift #(
  parameter int DATA_W = 8,
  parameter int SH     = 1
) (
  input  logic [DATA_W-1:0] d,
  input  logic              sel,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] y
);
  always_comb begin
    y = d;
    if (sel) begin
      case (mode)
        2'b00:   y = (d << SH) | (d >> (DATA_W - SH));
        2'b01:   y = (d >> SH) | (d << (DATA_W - SH));
        2'b10:   y = d << SH;
        default: y = $signed(d) >>> SH;  // MSB is still the original sign bit at every stage
      endcase
    end
  end
endmodule

module barrel_shifter_pipe #(
  parameter  int DATA_W = 8,
  parameter  int TAG_W  = 4,
  localparam int AMT_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [AMT_W-1:0]  in_amt,
  input  logic [1:0]        in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag
);
  localparam int S = AMT_W;

  logic                   advance;
  logic [S:0]             vld_pipe_q, vld_pipe_d;
  logic [S:0][DATA_W-1:0] data_q, data_d;
  logic [S:0][TAG_W-1:0]  tag_q, tag_d;
  logic [S-1:0][AMT_W-1:0] amt_q, amt_d;
  logic [S-1:0][1:0]      mode_q, mode_d;
  logic [S-1:0][DATA_W-1:0] shifted;

  assign advance   = !vld_pipe_q[S] || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_pipe_q[S];
  assign out_data  = data_q[S];
  assign out_tag   = tag_q[S];

  // amt_q[k] holds the amount already shifted right by k, so bit 0 selects this stage
  for (genvar k = 0; k < S; k++) begin : g_stage
    logic sel;
    if (k == S - 1) begin : g_last
      assign sel = |amt_q[k];
    end else begin : g_mid
      assign sel = amt_q[k][0];
    end
    bsp_shift #(.DATA_W(DATA_W), .SH(1 << k)) u_shift (
      .d(data_q[k]), .sel(sel), .mode(mode_q[k]), .y(shifted[k])
    );
  end

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    data_d     = data_q;
    tag_d      = tag_q;
    amt_d      = amt_q;
    mode_d     = mode_q;
    if (advance) begin
      vld_pipe_d[0] = in_valid;
      data_d[0]     = in_data;
      tag_d[0]      = in_tag;
      amt_d[0]      = in_amt;
      mode_d[0]     = in_mode;
      for (int k = 0; k < S; k++) begin
        vld_pipe_d[k+1] = vld_pipe_q[k];
        data_d[k+1]     = shifted[k];
        tag_d[k+1]      = tag_q[k];
      end
      for (int k = 1; k < S; k++) begin
        amt_d[k]  = amt_q[k-1] >> 1;
        mode_d[k] = mode_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_pipe_q <= '0;
      data_q     <= '0;
      tag_q      <= '0;
      amt_q      <= '0;
      mode_q     <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      data_q     <= data_d;
      tag_q      <= tag_d;
      amt_q      <= amt_d;
      mode_q     <= mode_d;
    end
  end
endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Bench for barrel_shifter_pipe: directed latency/stall/reset steps plus a random stream
// compared against an arithmetic reference model through an expected-word queue.

module tb_barrel_shifter_pipe;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid, in_ready;
  logic [7:0] in_data;
  logic [2:0] in_amt;
  logic [1:0] in_mode;
  logic [3:0] in_tag;
  logic       out_valid, out_ready;
  logic [7:0] out_data;
  logic [3:0] out_tag;

  int total = 0;
  int bad   = 0;
  logic last_acc;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  barrel_shifter_pipe #(.DATA_W(8), .TAG_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  function automatic logic [7:0] ref_calc(logic [7:0] d, int n, logic [1:0] m);
    int unsigned x    = 32'(d);
    int unsigned mask = 32'd255;
    int unsigned r;
    case (m)
      2'b00:   r = (x << n) | (x >> (8 - n));
      2'b01:   r = (x >> n) | (x << (8 - n));
      2'b10:   r = x << n;
      default: r = (x >> n) | (d[7] ? (mask & ~(mask >> n)) : 32'd0);
    endcase
    return r[7:0];
  endfunction

  task automatic chk(string name, logic [31:0] obs, logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, expv);
    end
  endtask

  // Called at a negedge with inputs already driven; covers one rising edge.
  task automatic cyc();
    logic [11:0] e;
    #1;
    last_acc = reset_n && in_valid && in_ready;
    if (!reset_n) exp_q.delete();
    else begin
      if (out_valid && out_ready) begin
        chk("out_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("out_data", 32'(out_data), 32'(e[7:0]));
          chk("out_tag", 32'(out_tag), 32'(e[11:8]));
        end
      end
      if (last_acc) exp_q.push_back({in_tag, ref_calc(in_data, int'(in_amt), in_mode)});
    end
    @(negedge clk);
  endtask

  task automatic send(logic [7:0] d, logic [2:0] a, logic [1:0] m, logic [3:0] t);
    in_valid = 1'b1; in_data = d; in_amt = a; in_mode = m; in_tag = t;
    for (int i = 0; i < 64; i++) begin
      cyc();
      if (last_acc) break;
    end
    chk("send_accept", 32'(last_acc), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain(int n);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (n) cyc();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_latency(logic [7:0] ed, logic [3:0] et);
    chk("lat_c1", 32'(out_valid), 32'd0); cyc();
    chk("lat_c2", 32'(out_valid), 32'd0); cyc();
    chk("lat_c3", 32'(out_valid), 32'd0); cyc();
    chk("lat_vld", 32'(out_valid), 32'd1);
    chk("lat_data", 32'(out_data), 32'(ed));
    chk("lat_tag", 32'(out_tag), 32'(et));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] hd;
    logic [3:0] ht;
    int cnt, cycles;
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0; in_mode = '0; in_tag = '0;
    out_ready = 1'b1;
    @(negedge clk);
    cyc(); cyc();
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_tag", 32'(out_tag), 32'd0);
    reset_n = 1'b1;
    #1 chk("rst_rdy", 32'(in_ready), 32'd1);

    // single word, latency
    send(8'h96, 3'd1, 2'b00, 4'h3);
    check_latency(8'h2D, 4'h3);
    drain(6);

    // four modes back-to-back, results on consecutive cycles
    send(8'h96, 3'd3, 2'b01, 4'h1);
    send(8'h96, 3'd4, 2'b10, 4'h2);
    send(8'h96, 3'd2, 2'b11, 4'h3);
    send(8'h16, 3'd2, 2'b11, 4'h4);
    chk("b2b_v0", 32'(out_valid), 32'd1); chk("b2b_d0", 32'(out_data), 32'hD2); cyc();
    chk("b2b_v1", 32'(out_valid), 32'd1); chk("b2b_d1", 32'(out_data), 32'hE5 ^ 32'h85); cyc();
    chk("b2b_v2", 32'(out_valid), 32'd1); chk("b2b_d2", 32'(out_data), 32'hE5); cyc();
    chk("b2b_v3", 32'(out_valid), 32'd1); chk("b2b_d3", 32'(out_data), 32'h05);
    drain(6);

    // amt=0 identity and the extreme amounts
    for (int m = 0; m < 4; m++) send(8'hA5, 3'd0, 2'(m), 4'(m));
    send(8'h01, 3'd7, 2'b00, 4'h5);
    send(8'h01, 3'd7, 2'b01, 4'h6);
    drain(8);

    // stream with a 4-cycle output stall
    for (int i = 0; i < 4; i++) send(8'(8'h31 + 8'(i * 37)), 3'(i + 1), 2'(i), 4'(i));
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'hC3; in_amt = 3'd5; in_mode = 2'b11; in_tag = 4'd4;
    #1;
    hd = out_data; ht = out_tag;
    chk("stall_vld", 32'(out_valid), 32'd1);
    repeat (4) begin
      chk("stall_rdy", 32'(in_ready), 32'd0);
      chk("stall_data", 32'(out_data), 32'(hd));
      chk("stall_tag", 32'(out_tag), 32'(ht));
      cyc();
    end
    out_ready = 1'b1;
    send(8'hC3, 3'd5, 2'b11, 4'd4);
    send(8'h7E, 3'd6, 2'b00, 4'd5);
    drain(8);

    // random valid/ready gaps
    cnt = 0; cycles = 0;
    while (cnt < 1000 && cycles < 20000) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = 8'($urandom);
      in_amt    = 3'($urandom);
      in_mode   = 2'($urandom);
      in_tag    = 4'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      cyc();
      if (last_acc) cnt++;
      cycles++;
    end
    chk("rand_count", 32'(cnt), 32'd1000);
    drain(10);

    // reset with two words in flight
    send(8'h11, 3'd1, 2'b00, 4'h8);
    send(8'h22, 3'd2, 2'b01, 4'h9);
    reset_n = 1'b0; in_valid = 1'b1; in_data = 8'h33;
    cyc();
    chk("rst2_vld", 32'(out_valid), 32'd0);
    chk("rst2_data", 32'(out_data), 32'd0);
    chk("rst2_tag", 32'(out_tag), 32'd0);
    in_valid = 1'b0; reset_n = 1'b1;
    #1 chk("rst2_rdy", 32'(in_ready), 32'd1);
    repeat (4) begin
      chk("no_stale", 32'(out_valid), 32'd0);
      cyc();
    end
    send(8'h5A, 3'd5, 2'b01, 4'h7);
    check_latency(8'hD2, 4'h7);
    drain(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/barrel_shifter_pipe.md
Name: barrel_shifter_pipe

Overview:
- Parametrised, pipelined shift/rotate unit; successor to the 8-bit combinational left rotator.
- Supports generic power-of-two width, four operating modes, and one register per shift stage.
- Uses a valid/ready stream handshake and carries a user tag through with the data.
- Sits between a stream producer (e.g. UART/DSP datapath) and its consumer in the FPGA prototyping designs.

Parameters:
- DATA_W, 8, data width in bits; must be a power of two, >= 2.
- TAG_W, 4, width of the opaque sideband tag carried alongside each word.
- AMT_W, $clog2(DATA_W), width of the shift amount (derived, not overridden).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input word present.
- in_ready  out  1  unit can accept input this cycle.
- in_data  in  DATA_W  operand.
- in_amt  in  AMT_W  shift/rotate amount, 0..DATA_W-1.
- in_mode  in  2  00 ROL, 01 ROR, 10 SLL (logical left, zero fill), 11 SRA (arithmetic right, sign fill).
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_data  out  DATA_W  result.
- out_tag  out  TAG_W  tag of the word in out_data.

Behaviour:
- Reset (reset_n sampled low at a clk edge):
  - All stage valid bits, out_valid, out_data and out_tag are cleared to 0.
  - In-flight words are discarded.
  - in_ready is 1 in the first cycle after reset is released.
- Pipeline structure:
  - AMT_W stages; stage k applies a shift of 0 or 2^k bits, selected by amt bit k.
  - Each stage registers data, remaining amt, mode, tag and valid.
  - Latency is exactly AMT_W cycles from the accepting edge to out_valid=1, with no stall (3 cycles at DATA_W=8).
  - Throughput is one word per cycle.
- Result definitions (n = amt, W = DATA_W):
  - ROL: (d << n) | (d >> (W-n)), mod 2^W.
  - ROR: (d >> n) | (d << (W-n)), mod 2^W.
  - SLL: (d << n), mod 2^W.
  - SRA: d >> n, with the vacated bits filled from d[W-1] as sampled at input.
  - n=0: out_data = in_data in every mode.
- Handshake:
  - Transfer occurs when valid && ready on the same edge.
  - advance = !out_valid || out_ready; in_ready = advance; every stage register updates only when advance=1.
  - The stall is global; bubbles are not squeezed out.
  - While out_valid=1 and out_ready=0, out_data, out_tag and out_valid hold stable and in_ready=0.
  - in_valid=0 while advance=1 inserts a bubble (valid=0) that propagates through the pipeline.
- Ordering and integrity: words leave in acceptance order; no loss, no duplication; the tag stays aligned with its data.
- Simultaneous events:
  - An input accept and an output accept in the same cycle are both honoured.
  - A reset in the same cycle as any handshake wins; nothing is accepted or emitted.
- Output register contents when out_valid=0 are don't-care after reset, but must not be X in simulation.

Test Plan:
- DATA_W=8, ROL, in_data=0x96, amt=1, tag=0x3, out_ready=1 -> out_valid rises 3 cycles after the accept; out_data=0x2D, out_tag=0x3.
- ROR 0x96 amt=3 -> 0xD2; SLL 0x96 amt=4 -> 0x60; SRA 0x96 amt=2 -> 0xE5; SRA 0x16 amt=2 -> 0x05; all four issued back-to-back -> results on 4 consecutive cycles, in order.
- amt=0 in all modes with 0xA5 -> 0xA5 each; ROL 0x01 amt=7 -> 0x80; ROR 0x01 amt=7 -> 0x02.
- Stream 6 words with incrementing tags; drop out_ready for 4 cycles mid-stream:
  - out_data and out_tag hold stable and in_ready=0 during the stall.
  - After release, all 6 words emerge in tag order with none lost or duplicated.
- Random in_valid/out_ready gaps, 1000 words, checked against a reference model -> zero mismatches, order preserved.
- Assert reset_n=0 with 2 words in flight -> out_valid=0 and out_data=0 on the next edge; after release, the first new word appears with 3-cycle latency and no stale output.
